interp_out_stage: RTL
=====================

# interp_out_stage

Output stage of the polyphase FIR lowpass interpolator, directly downstream of the dual-phase MAC. Once per input sample it captures both phase accumulators and differences each against its previous capture, because the MAC accumulators are never cleared. It then rounds and narrows the two results to SAMPLE_SIZE and queues them phase A first, phase B second. The output is a 2× rate valid/ready stream.

## Interface
- SAMPLE_SIZE, 16, output sample width (Q1.15)
- COEFF_SIZE, 16, coefficient width; ACC_SIZE = SAMPLE_SIZE+COEFF_SIZE (Q2.30)
- OUT_SHIFT, 15, arithmetic right shift from accumulator to output
- FIFO_DEPTH, 4, output queue entries; power of 2, ≥4
- clk  in  1  clock, rising edge
- nrst  in  1  asynchronous active-low reset
- soft_clr  in  1  synchronous clear; same effect as reset except err_drop is kept
- acc_valid  in  1  one-cycle strobe: acc_a/acc_b hold final sums for this sample
- acc_a  in  ACC_SIZE  phase-A accumulator, signed
- acc_b  in  ACC_SIZE  phase-B accumulator, signed
- acc_ready  out  1  a pair can be accepted this cycle
- m_valid  out  1  m_data is valid
- m_ready  in  1  downstream accepts m_data
- m_data  out  SAMPLE_SIZE  output sample, signed
- err_drop  out  1  sticky: acc_valid arrived while acc_ready=0
- sat_cnt  out  16  saturation event count; present only with INTERP_OUT_SAT_EN

## Operation
- **Reset and soft_clr**
  - prev_a, prev_b, stage-1 registers, FIFO pointers and count are set to 0.
  - Reset also clears err_drop and sat_cnt.
  - Output reset values: m_valid=0, m_data=0, acc_ready=1, err_drop=0, sat_cnt=0.
- **Stage 1** (on acc_valid && acc_ready)
  - d_a = acc_a − prev_a and d_b = acc_b − prev_b, both modulo 2^ACC_SIZE.
  - Registers prev_a=acc_a, prev_b=acc_b and s1_valid=1.
- **Stage 2** (s1_valid)
  - r = (d + 2^(OUT_SHIFT−1)) >>> OUT_SHIFT: round half up, signed, computed at ACC_SIZE+1 bits.
  - r is narrowed to SAMPLE_SIZE.
  - r_a and r_b are written into the FIFO in the same cycle, r_a at wr_ptr and r_b at wr_ptr+1; wr_ptr += 2.
- **FIFO**
  - m_data = mem[rd_ptr]; m_valid = (count≠0).
  - A pop occurs on m_valid && m_ready.
  - Simultaneous push and pop: count += 2−1.
- **Flow control**
  - acc_ready = (FIFO_DEPTH − count − 2·s1_valid) ≥ 2, where s1_valid is the in-flight pair not yet written.
- **Drop**
  - acc_valid while acc_ready=0: the pair is discarded, prev is not updated, err_drop is set.
- **Wrap-around**
  - Accumulator overflow in the MAC is harmless; the modulo difference stays correct.
  - Pointers wrap modulo FIFO_DEPTH.
- **soft_clr with acc_valid in the same cycle**: soft_clr wins and the pair is ignored; no drop is flagged.

## Timing
- acc_valid sampled at edge T → s1_valid high in T+1 → FIFO written at edge T+1.
- m_valid rises in cycle T+2 with m_data = r_a when the FIFO was empty.
- r_b is presented the cycle after r_a is popped.
- With m_ready held at 1, back-to-back acc_valid every cycle sustains 1 output per cycle until the FIFO fills; acc_ready then drops.
- Minimum sustained acc_valid spacing is 2 cycles with m_ready=1.
- Outputs are registered or driven directly from registers/FIFO memory; there is no combinational path from acc_* to m_*.

## Configuration
- INTERP_OUT_SAT_EN defined:
  - r is clamped to [−2^(SAMPLE_SIZE−1), 2^(SAMPLE_SIZE−1)−1].
  - sat_cnt increments by the number of saturated values per pair (0–2) and saturates at 0xFFFF.
- INTERP_OUT_SAT_EN undefined:
  - m_data takes the low SAMPLE_SIZE bits of r (wraps).
  - The sat_cnt port and its logic are absent.

## Structure
- Package interp_pkg holds ACC_SIZE derivation, OUT_SHIFT default, and the round_narrow function (round plus optional clamp, returning the value and a sat flag).
- Sub-module sync_fifo_2w1r: FIFO with one 2-entry write port and one 1-entry read port, parameterised by width and depth, exposing count.

## Test plan
- Reset, then acc_valid with acc_a=0x0001_0000 and acc_b=0x0000_8000 → m_data 0x0002 then 0x0001; m_valid first high 2 cycles after the strobe.
- Follow with acc_a=0x0001_8000 and acc_b=0x0000_8000 → deltas 0x8000 and 0 → m_data 0x0001 then 0x0000.
- Rounding and saturation from reset, pair 0x3FFF_C000 / 0xFFFF_BFFF:
  - With INTERP_OUT_SAT_EN: m_data 0x7FFF, 0xFFFF; sat_cnt=1.
  - Without INTERP_OUT_SAT_EN: m_data 0x8000, 0xFFFF.
- Backpressure, m_ready=0, FIFO_DEPTH=4:
  - Two pairs → acc_ready=0.
  - A third strobe → err_drop=1, and the later output sequence has no third pair.
  - Raise m_ready → 4 samples in order.
- Accumulator wrap: prev=0x7FFF_8000, next=0x8000_0000 → delta 0x8000 → m_data 0x0001.
- Edge cases:
  - nrst asserted mid-stream → all outputs return to their reset values immediately.
  - soft_clr with an entry queued → m_valid=0 next cycle, err_drop kept.

Source files
------------

// File: rtl/interp_pkg.sv
// -----------------------------------------------------------------------------
// interp_pkg
// Shared definitions for the interpolator output stage.
//   - Default widths and shift (sample, coefficient, output shift, FIFO depth).
//   - acc_width(): accumulator width derived from sample and coefficient widths.
//   - round_narrow(): round-half-up arithmetic shift of a sign-extended
//     difference. When INTERP_OUT_SAT_EN is defined it also clamps the result
//     to the signed sample range and reports whether it clamped.
// Optional feature macro: INTERP_OUT_SAT_EN
// -----------------------------------------------------------------------------
package interp_pkg;

  localparam int SAMPLE_SIZE_DEF = 16;
  localparam int COEFF_SIZE_DEF  = 16;
  localparam int OUT_SHIFT_DEF   = 15;
  localparam int FIFO_DEPTH_DEF  = 4;

  // Working width for rounding; wide enough for any ACC_SIZE+1 up to 63 bits.
  localparam int RN_W = 64;

  typedef struct packed {
    logic signed [RN_W-1:0] val;
    logic                   sat;
  } rn_t;

  function automatic int acc_width(input int sample_size, input int coeff_size);
    return sample_size + coeff_size;
  endfunction

  // The caller sign-extends d, so the add cannot overflow the working width.
  function automatic rn_t round_narrow(input logic signed [RN_W-1:0] d,
                                       input int                     shift,
                                       input int                     sample_size);
    logic signed [RN_W-1:0] r;
    rn_t                    res;
    r       = (d + (64'sd1 <<< (shift - 1))) >>> shift;
    res.val = r;
    res.sat = 1'b0;
`ifdef INTERP_OUT_SAT_EN
    begin
      logic signed [RN_W-1:0] hi;
      logic signed [RN_W-1:0] lo;
      hi = (64'sd1 <<< (sample_size - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (r > hi) begin
        res.val = hi;
        res.sat = 1'b1;
      end else if (r < lo) begin
        res.val = lo;
        res.sat = 1'b1;
      end else begin
        res.val = r;
        res.sat = 1'b0;
      end
    end
`else
    if (sample_size < 1) begin
      res.sat = 1'b0;
    end else begin
      res.sat = 1'b0;
    end
`endif
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo_2w1r.sv
// -----------------------------------------------------------------------------
// sync_fifo_2w1r
// FIFO with a two-entry write port and a one-entry read port.
//   clk, nrst      : clock, asynchronous active-low reset
//   clr_i          : synchronous clear (pointers, count and memory to zero)
//   push_i         : write wdata0_i at wr_ptr and wdata1_i at wr_ptr+1
//   wdata0_i/1_i   : the two entries written by one push
//   pop_i          : remove the head entry (caller guarantees count_o != 0)
//   rdata_o        : head entry, read straight from memory
//   count_o        : number of entries held
// The caller guarantees room for two entries whenever push_i is high.
// -----------------------------------------------------------------------------
module sync_fifo_2w1r #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata0_i,
  input  logic [WIDTH-1:0]           wdata1_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  // Occupancy after this cycle's push (+2) and pop (-1).
  always_comb begin
    count_d = count_q;
    if (push_i && pop_i) begin
      count_d = count_q + CW'(1);
    end else if (push_i) begin
      count_d = count_q + CW'(2);
    end else if (pop_i) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Storage, pointers and count; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q]          <= wdata0_i;
        mem_q[wr_ptr_q + AW'(1)] <= wdata1_i;
        wr_ptr_q                 <= wr_ptr_q + AW'(2);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/interp_out_stage.sv
// -----------------------------------------------------------------------------
// interp_out_stage
// Output stage of the polyphase interpolator. Each accepted accumulator pair is
// differenced against the previous accepted pair (the MAC never clears), then
// rounded, narrowed and queued phase A first, phase B second.
//   clk, nrst  : clock, asynchronous active-low reset
//   soft_clr   : synchronous clear, same as reset except err_drop is kept
//   acc_valid  : strobe, acc_a/acc_b hold this sample's final sums
//   acc_a/b    : phase accumulators, signed, ACC_SIZE bits
//   acc_ready  : a pair can be accepted this cycle
//   m_valid/m_ready/m_data : output stream, SAMPLE_SIZE bits signed
//   err_drop   : sticky, a strobe arrived while acc_ready was low
//   sat_cnt    : saturation event count (only with INTERP_OUT_SAT_EN)
// Optional feature macro: INTERP_OUT_SAT_EN (clamp instead of wrap, sat_cnt)
// -----------------------------------------------------------------------------
module interp_out_stage
  import interp_pkg::*;
#(
  parameter  int SAMPLE_SIZE = SAMPLE_SIZE_DEF,
  parameter  int COEFF_SIZE  = COEFF_SIZE_DEF,
  parameter  int OUT_SHIFT   = OUT_SHIFT_DEF,
  parameter  int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  localparam int ACC_SIZE    = acc_width(SAMPLE_SIZE, COEFF_SIZE)
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   soft_clr,
  input  logic                   acc_valid,
  input  logic [ACC_SIZE-1:0]    acc_a,
  input  logic [ACC_SIZE-1:0]    acc_b,
  output logic                   acc_ready,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [SAMPLE_SIZE-1:0] m_data,
  output logic                   err_drop
`ifdef INTERP_OUT_SAT_EN
  ,output logic [15:0]           sat_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [ACC_SIZE-1:0] prev_a_q, prev_a_d;
  logic [ACC_SIZE-1:0] prev_b_q, prev_b_d;
  logic [ACC_SIZE-1:0] d_a_q, d_a_d;
  logic [ACC_SIZE-1:0] d_b_q, d_b_d;
  logic                s1_valid_q, s1_valid_d;
  logic                err_drop_q, err_drop_d;
  logic                accept_s, drop_s, pop_s;
  logic [CNT_W-1:0]    count_s;
  logic [CNT_W:0]      used_s;
  rn_t                 rn_a_s, rn_b_s;
  logic                unused_s;

  assign accept_s = acc_valid && acc_ready && !soft_clr;
  assign drop_s   = acc_valid && !acc_ready && !soft_clr;

  // Room check counts the in-flight pair that stage 2 has not written yet.
  assign used_s    = {1'b0, count_s} + (s1_valid_q ? (CNT_W+1)'(2) : (CNT_W+1)'(0));
  assign acc_ready = (used_s <= (CNT_W+1)'(FIFO_DEPTH - 2));
  assign m_valid   = (count_s != '0);
  assign pop_s     = m_valid && m_ready;
  assign err_drop  = err_drop_q;

  // Stage-1 next state: modulo difference against the last accepted pair.
  always_comb begin
    prev_a_d   = prev_a_q;
    prev_b_d   = prev_b_q;
    d_a_d      = d_a_q;
    d_b_d      = d_b_q;
    s1_valid_d = 1'b0;
    if (accept_s) begin
      d_a_d      = acc_a - prev_a_q;
      d_b_d      = acc_b - prev_b_q;
      prev_a_d   = acc_a;
      prev_b_d   = acc_b;
      s1_valid_d = 1'b1;
    end else begin
      s1_valid_d = 1'b0;
    end
  end

  // Sticky drop flag next state.
  always_comb begin
    err_drop_d = err_drop_q;
    if (drop_s) begin
      err_drop_d = 1'b1;
    end else begin
      err_drop_d = err_drop_q;
    end
  end

  // Stage-1 registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prev_a_q   <= '0;
      prev_b_q   <= '0;
      d_a_q      <= '0;
      d_b_q      <= '0;
      s1_valid_q <= 1'b0;
    end else if (soft_clr) begin
      prev_a_q   <= '0;
      prev_b_q   <= '0;
      d_a_q      <= '0;
      d_b_q      <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      prev_a_q   <= prev_a_d;
      prev_b_q   <= prev_b_d;
      d_a_q      <= d_a_d;
      d_b_q      <= d_b_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  // Drop flag register; survives soft_clr.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_drop_q <= 1'b0;
    end else begin
      err_drop_q <= err_drop_d;
    end
  end

  // Stage 2: round both differences (sign-extended) on their way into the FIFO.
  assign rn_a_s = round_narrow({{(RN_W-ACC_SIZE){d_a_q[ACC_SIZE-1]}}, d_a_q}, OUT_SHIFT, SAMPLE_SIZE);
  assign rn_b_s = round_narrow({{(RN_W-ACC_SIZE){d_b_q[ACC_SIZE-1]}}, d_b_q}, OUT_SHIFT, SAMPLE_SIZE);
  assign unused_s = ^{rn_a_s.val[RN_W-1:SAMPLE_SIZE], rn_b_s.val[RN_W-1:SAMPLE_SIZE],
                      rn_a_s.sat, rn_b_s.sat};

  sync_fifo_2w1r #(
    .WIDTH (SAMPLE_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .nrst     (nrst),
    .clr_i    (soft_clr),
    .push_i   (s1_valid_q),
    .wdata0_i (rn_a_s.val[SAMPLE_SIZE-1:0]),
    .wdata1_i (rn_b_s.val[SAMPLE_SIZE-1:0]),
    .pop_i    (pop_s),
    .rdata_o  (m_data),
    .count_o  (count_s)
  );

`ifdef INTERP_OUT_SAT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;
  logic [16:0] sat_sum_s;

  assign sat_sum_s = {1'b0, sat_cnt_q} + {16'd0, rn_a_s.sat} + {16'd0, rn_b_s.sat};
  assign sat_cnt   = sat_cnt_q;

  // Saturation counter next state, stuck at all-ones once full.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (s1_valid_q) begin
      sat_cnt_d = sat_sum_s[16] ? 16'hFFFF : sat_sum_s[15:0];
    end else begin
      sat_cnt_d = sat_cnt_q;
    end
  end

  // Saturation counter register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sat_cnt_q <= 16'd0;
    end else if (soft_clr) begin
      sat_cnt_q <= 16'd0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end
`endif

endmodule
